// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes, memory-wait freeze,
// ecall/timeout halt, and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       d_rs1_index,
    input  logic [4:0]       d_rs2_index,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [4:0]       e_rd_index,
    input  logic             e_wb_en,
    input  logic             e_wb_sel,
    input  logic             e_ecall_sig,
    input  logic             br_taken,
    input  logic             dm_req,
    input  logic             dm_ready,
    output logic             stall_f,
    output logic             stall_e,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             halt,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t           state_q;
    logic [WW-1:0]    wait_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             tmo_q;

    logic load_use, mem_miss, br_flush;
    logic sf, se, ffd, fde, hlt;

    assign load_use = e_wb_en & e_wb_sel & (e_rd_index != 5'd0) &
                      ((d_use_rs1 & (d_rs1_index == e_rd_index)) |
                       (d_use_rs2 & (d_rs2_index == e_rd_index)));
    assign mem_miss = dm_req & ~dm_ready;
    assign br_flush = (state_q == RUN) & ~e_ecall_sig & ~mem_miss & br_taken;

    always_comb begin
        sf  = 1'b0;
        se  = 1'b0;
        ffd = 1'b0;
        fde = 1'b0;
        hlt = 1'b0;
        case (state_q)
            RUN: begin
                if (e_ecall_sig) begin
                    ffd = 1'b1;
                    fde = 1'b1;
                end else if (mem_miss) begin
                    sf = 1'b1;
                    se = 1'b1;
                end else if (br_taken) begin
                    ffd = 1'b1;
                    fde = 1'b1;
                end else if (load_use) begin
                    sf  = 1'b1;
                    fde = 1'b1;
                end
            end
            MEM_WAIT: begin
                sf = 1'b1;
                se = 1'b1;
            end
            HALT: begin
                hlt = 1'b1;
                sf  = 1'b1;
                ffd = 1'b1;
                fde = 1'b1;
            end
            default: ;
        endcase
    end

    // Combinational controls are masked during reset so the pipe sees no stray flush/stall.
    assign stall_f     = sf  & rst;
    assign stall_e     = se  & rst;
    assign flush_fd    = ffd & rst;
    assign flush_de    = fde & rst;
    assign halt        = hlt & rst;
    assign timeout_err = tmo_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            tmo_q       <= 1'b0;
        end else begin
            if (sf && state_q != HALT && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (br_flush && flush_cnt_q != {CNT_W{1'b1}})
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            case (state_q)
                RUN: begin
                    if (e_ecall_sig) begin
                        state_q <= HALT;
                    end else if (mem_miss) begin
                        state_q <= MEM_WAIT;
                        wait_q  <= WW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dm_ready) begin
                        state_q <= RUN;
                        wait_q  <= '0;
                    end else if (wait_q == WW'(MEM_TIMEOUT)) begin
                        state_q <= HALT;
                        tmo_q   <= 1'b1;
                    end else begin
                        wait_q  <= wait_q + WW'(1);
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a cycle-level behavioural model;
// a second instance with 4-bit counters exercises saturation.
module tb_hazard_ctrl;
    localparam int TMO = 16;

    logic       clk = 1'b0, rst = 1'b0;
    logic [4:0] d_rs1_index, d_rs2_index, e_rd_index;
    logic       d_use_rs1, d_use_rs2, e_wb_en, e_wb_sel, e_ecall_sig, br_taken, dm_req, dm_ready;

    logic        stall_f, stall_e, flush_fd, flush_de, halt, timeout_err;
    logic [31:0] stall_cnt, flush_cnt;
    logic        b_stall_f, b_stall_e, b_flush_fd, b_flush_de, b_halt, b_timeout_err;
    logic [3:0]  b_stall_cnt, b_flush_cnt;

    hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .d_rs1_index(d_rs1_index), .d_rs2_index(d_rs2_index),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .e_rd_index(e_rd_index), .e_wb_en(e_wb_en),
        .e_wb_sel(e_wb_sel), .e_ecall_sig(e_ecall_sig), .br_taken(br_taken), .dm_req(dm_req),
        .dm_ready(dm_ready), .stall_f(stall_f), .stall_e(stall_e), .flush_fd(flush_fd),
        .flush_de(flush_de), .halt(halt), .timeout_err(timeout_err), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt));

    hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .d_rs1_index(d_rs1_index), .d_rs2_index(d_rs2_index),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .e_rd_index(e_rd_index), .e_wb_en(e_wb_en),
        .e_wb_sel(e_wb_sel), .e_ecall_sig(e_ecall_sig), .br_taken(br_taken), .dm_req(dm_req),
        .dm_ready(dm_ready), .stall_f(b_stall_f), .stall_e(b_stall_e), .flush_fd(b_flush_fd),
        .flush_de(b_flush_de), .halt(b_halt), .timeout_err(b_timeout_err), .stall_cnt(b_stall_cnt),
        .flush_cnt(b_flush_cnt));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Model: mode 0 = running, 1 = waiting on memory, 2 = halted.
    int     m_mode, m_waited;
    longint m_stall, m_flush;
    bit     m_tmo;
    bit     x_sf, x_se, x_ffd, x_fde, x_halt, x_brflush;

    function automatic longint sat(input longint v, input int w);
        longint lim = (longint'(1) << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_tmo = 0;
    endtask

    task automatic model_outs();
        bit hazard, miss;
        hazard = e_wb_en && e_wb_sel && e_rd_index != 0 &&
                 ((d_use_rs1 && d_rs1_index == e_rd_index) || (d_use_rs2 && d_rs2_index == e_rd_index));
        miss = dm_req && !dm_ready;
        {x_sf, x_se, x_ffd, x_fde, x_halt, x_brflush} = '0;
        if (m_mode == 2) {x_halt, x_sf, x_ffd, x_fde} = 4'b1111;
        else if (m_mode == 1) {x_sf, x_se} = 2'b11;
        else if (e_ecall_sig) {x_ffd, x_fde} = 2'b11;
        else if (miss) {x_sf, x_se} = 2'b11;
        else if (br_taken) begin {x_ffd, x_fde} = 2'b11; x_brflush = 1; end
        else if (hazard) {x_sf, x_fde} = 2'b11;
    endtask

    task automatic model_next();
        model_outs();
        if (m_mode != 2 && x_sf) m_stall++;
        if (x_brflush) m_flush++;
        if (m_mode == 0) begin
            if (e_ecall_sig) m_mode = 2;
            else if (dm_req && !dm_ready) begin m_mode = 1; m_waited = 0; end
        end else if (m_mode == 1) begin
            if (dm_ready) m_mode = 0;
            else begin
                m_waited++;
                if (m_waited == TMO) begin m_mode = 2; m_tmo = 1; end
            end
        end
    endtask

    task automatic check_all(input string tag);
        model_outs();
        chk({tag, ".stall_f"},  stall_f,  x_sf);
        chk({tag, ".stall_e"},  stall_e,  x_se);
        chk({tag, ".flush_fd"}, flush_fd, x_ffd);
        chk({tag, ".flush_de"}, flush_de, x_fde);
        chk({tag, ".halt"},     halt,     x_halt);
        chk({tag, ".tmo"},      timeout_err, m_tmo);
        chk({tag, ".stall_cnt"}, stall_cnt, sat(m_stall, 32));
        chk({tag, ".flush_cnt"}, flush_cnt, sat(m_flush, 32));
        chk({tag, ".sat_stall"}, b_stall_cnt, sat(m_stall, 4));
        chk({tag, ".sat_flush"}, b_flush_cnt, sat(m_flush, 4));
        chk({tag, ".sat_halt"},  b_halt, x_halt);
    endtask

    // Called just after a rising edge; checks before the falling (state) edge.
    task automatic step(input string tag);
        #2 check_all(tag);
        @(negedge clk);
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".stall_f"}, stall_f, 0);
        chk({tag, ".stall_e"}, stall_e, 0);
        chk({tag, ".flush_fd"}, flush_fd, 0);
        chk({tag, ".flush_de"}, flush_de, 0);
        chk({tag, ".halt"}, halt, 0);
        chk({tag, ".tmo"}, timeout_err, 0);
        chk({tag, ".stall_cnt"}, stall_cnt, 0);
        chk({tag, ".flush_cnt"}, flush_cnt, 0);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b0;
        #1 check_zero(tag);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic idle();
        {d_rs1_index, d_rs2_index, e_rd_index} = '0;
        {d_use_rs1, d_use_rs2, e_wb_en, e_wb_sel, e_ecall_sig, br_taken, dm_req, dm_ready} = '0;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        idle();
        e_wb_en = 1; e_wb_sel = 1; e_rd_index = rd; d_use_rs1 = 1; d_rs1_index = rd;
    endtask

    int halted_for;

    initial begin
        idle();
        model_reset();
        #1 check_zero("por");
        @(posedge clk);
        #1 rst = 1'b1;

        set_lu(5'd5);  step("lu");
        idle();        step("lu_after");
        chk("lu_cnt", stall_cnt, 1);
        set_lu(5'd0);  step("lu_x0");
        chk("lu_x0_f", stall_f, 0);
        chk("lu_x0_cnt", stall_cnt, 1);

        do_reset("rst1");
        set_lu(5'd5); br_taken = 1; step("br_lu");
        idle(); step("br_after");
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 0);

        do_reset("rst2");
        idle(); dm_req = 1;
        for (int i = 0; i < 3; i++) begin
            br_taken = (i == 1);
            step("memw");
        end
        br_taken = 0; dm_ready = 1; step("memw_rdy");
        idle(); step("memw_run");
        chk("memw_stall_cnt", stall_cnt, 4);
        chk("memw_flush_cnt", flush_cnt, 0);

        do_reset("rst3");
        idle(); dm_req = 1;
        for (int i = 0; i < 20; i++) step("tmo");
        chk("tmo_err", timeout_err, 1);
        chk("tmo_halt", halt, 1);

        do_reset("rst4");
        idle(); e_ecall_sig = 1; step("ecall");
        for (int i = 0; i < 3; i++) begin
            set_lu(5'd3); br_taken = 1; step("halted");
        end
        chk("ecall_halt", halt, 1);
        chk("ecall_stall_cnt", stall_cnt, 0);
        do_reset("rst_halt");
        idle(); step("post_halt");

        do_reset("rst5");
        set_lu(5'd7);
        for (int i = 0; i < 20; i++) step("sat");
        chk("sat_stall4", b_stall_cnt, 15);
        chk("sat_stall32", stall_cnt, 20);

        do_reset("rst6");
        halted_for = 0;
        for (int n = 0; n < 3000; n++) begin
            d_rs1_index = 5'($urandom_range(0, 3));
            d_rs2_index = 5'($urandom_range(0, 3));
            e_rd_index  = 5'($urandom_range(0, 3));
            d_use_rs1   = 1'($urandom);
            d_use_rs2   = 1'($urandom);
            e_wb_en     = ($urandom_range(0, 3) != 0);
            e_wb_sel    = 1'($urandom);
            e_ecall_sig = ($urandom_range(0, 63) == 0);
            br_taken    = ($urandom_range(0, 3) == 0);
            dm_req      = ($urandom_range(0, 2) == 0);
            dm_ready    = (n % 400 < 300) ? 1'($urandom) : 1'b0;
            step("rnd");
            halted_for = (m_mode == 2) ? halted_for + 1 : 0;
            if (halted_for > 4 || $urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
                halted_for = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and stall controller that drives the flush/stall inputs of the F/D and D/E pipeline registers. It watches decode-stage source indices, the execute-stage destination/control word, branch resolution, ecall and the data-memory handshake. It then emits bubble, flush, freeze and halt controls. It also holds a small state machine for multi-cycle memory waits and halt, plus saturating performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before a timeout error
CNT_W, 32, width of the stall and flush performance counters

Ports:
clk  input  1  pipeline clock; all state updates on falling edge, matching pipeline registers
rst  input  1  asynchronous active-low reset
d_rs1_index  input  5  rs1 index in decode stage
d_rs2_index  input  5  rs2 index in decode stage
d_use_rs1  input  1  decode instruction reads rs1
d_use_rs2  input  1  decode instruction reads rs2
e_rd_index  input  5  rd index held in D/E register
e_wb_en  input  1  execute-stage instruction writes back
e_wb_sel  input  1  execute-stage writeback source is data memory (load)
e_ecall_sig  input  1  execute-stage instruction is ecall
br_taken  input  1  branch/jump resolved taken in execute
dm_req  input  1  memory-stage access in progress
dm_ready  input  1  data memory completes access this cycle
stall_f  output  1  hold PC and F/D register
stall_e  output  1  hold D/E and later registers
flush_fd  output  1  replace F/D content with NOP
flush_de  output  1  bubble D/E control fields
halt  output  1  core halted
timeout_err  output  1  sticky memory-timeout flag
stall_cnt  output  CNT_W  cycles with stall_f=1 outside HALT
flush_cnt  output  CNT_W  taken-branch flushes

Behaviour:
- Reset (rst=0, async): state=RUN, wait counter=0, counters=0, timeout_err=0. All outputs are forced 0 while rst=0.
- load_use = e_wb_en & e_wb_sel & (e_rd_index!=0) & ((d_use_rs1 & d_rs1_index==e_rd_index) | (d_use_rs2 & d_rs2_index==e_rd_index)).
- The outputs below are combinational from state and inputs. Next state, wait counter and counters register on the falling edge.
- RUN, priority high to low:
  1. e_ecall_sig: flush_fd=1, flush_de=1; next=HALT.
  2. dm_req & !dm_ready: stall_f=1, stall_e=1, flushes=0; next=MEM_WAIT, wait counter=1.
  3. br_taken: flush_fd=1, flush_de=1; flush_cnt+1. A simultaneous load_use is ignored because the branch wins.
  4. load_use: stall_f=1, flush_de=1 (one bubble). Next cycle the load has left E, so load_use clears naturally.
  5. Otherwise all controls are 0.
- MEM_WAIT: stall_f=1, stall_e=1, flush_fd=0, flush_de=0. br_taken and load_use are masked because the pipe is frozen.
  - dm_ready=1: this cycle still stalls; next=RUN, wait counter=0.
  - Wait counter reaches MEM_TIMEOUT without dm_ready: timeout_err<=1, next=HALT.
  - Otherwise wait counter+1.
- HALT: halt=1, stall_f=1, flush_fd=1, flush_de=1, stall_e=0. The state is absorbing, left only by reset. Counters frozen.
- stall_cnt increments on every cycle where stall_f=1 and state!=HALT (including the ecall cycle if stalled, which it is not).
- Both counters saturate at all-ones and never wrap.
- x0 destination never creates a hazard. Index compares are exact 5-bit.
- Reset asserted mid-MEM_WAIT or in HALT returns immediately to RUN with counters cleared.

Test Plan:
- Load-use: e_wb_en=1, e_wb_sel=1, e_rd_index=5, d_use_rs1=1, d_rs1_index=5 for one cycle -> stall_f=1, flush_de=1 that cycle only; stall_cnt=1. Repeat with e_rd_index=0 -> no stall.
- Branch vs load-use: br_taken=1 together with the load-use condition above -> flush_fd=1, flush_de=1, stall_f=0; flush_cnt=1, stall_cnt=0.
- Memory wait: dm_req=1, dm_ready=0 for 3 cycles, then dm_ready=1 -> stall_f=stall_e=1 for 4 cycles, then RUN; stall_cnt=4; br_taken pulsed during the wait gives no flush.
- Timeout: dm_req=1, dm_ready=0 held for 20 cycles with MEM_TIMEOUT=16 -> timeout_err=1 and halt=1 after the 16th wait cycle; both stay 1.
- Ecall: e_ecall_sig=1 in RUN -> flush_fd=flush_de=1 that cycle, halt=1 from the next cycle onward, counters frozen. Async rst=0 mid-halt -> all outputs 0 immediately; after release, state is RUN.
- Saturation: CNT_W=4, hold load-use for 20 cycles -> stall_cnt sticks at 15.
